// File: rtl/deaccumulation.sv
// Purpose : dispenses a loaded balance in requested chunks, saturating at what is left.
// Latency : 1 cycle from a sampled req to dout/valid; remain/ngrant update on the same edge.
// Backpressure: none; every request made in DRAIN without a load is granted at once.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   load   - latch total as the new balance (takes priority over req)
//   total  - balance to load (AW bits)
//   req    - dispense request, sampled on the rising edge
//   amt    - requested dispense amount (DW bits)
//   dout   - granted amount, registered
//   valid  - one-cycle pulse when dout carries a fresh grant
//   remain - current balance, registered
//   busy   - high while draining
//   empty  - high when remain is zero
//   ngrant - grants since the last load, wraps at 16
//
// DW must not exceed AW: amounts are zero-extended to AW bits before use.

module deaccumulation #(
  parameter int DW = 4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] total,
  input  logic          req,
  input  logic [DW-1:0] amt,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic [AW-1:0] remain,
  output logic          busy,
  output logic          empty,
  output logic [3:0]    ngrant
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [DW-1:0] r_dout;
  logic          r_valid;
  logic [AW-1:0] r_remain;
  logic [3:0]    r_ngrant;

  logic [AW-1:0] w_amt_ext;
  logic [AW-1:0] w_grant;
  logic [AW-1:0] w_remain_after;
  logic          w_accept;
  logic          w_busy;

  // Compare and subtract at balance width so a large amt never wraps remain.
  assign w_amt_ext      = AW'(amt);
  assign w_grant        = (w_amt_ext > r_remain) ? r_remain : w_amt_ext;
  assign w_remain_after = r_remain - w_grant;

  // A request only counts while draining, and a simultaneous load wins.
  assign w_accept = (r_state == S_DRAIN) && req && !load;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (load) begin
      w_next_state = (total != '0) ? S_DRAIN : S_DONE;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_IDLE;
        S_DRAIN: begin
          // Leave DRAIN on the very edge that takes the last unit.
          if (req && (w_remain_after == '0)) begin
            w_next_state = S_DONE;
          end
        end
        S_DONE:  w_next_state = S_DONE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_DRAIN: w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_remain <= '0;
      r_ngrant <= '0;
    end else if (load) begin
      // dout keeps the previous grant across a reload.
      r_remain <= total;
      r_ngrant <= '0;
      r_valid  <= 1'b0;
    end else if (w_accept) begin
      // A saturated grant is below amt, so it always fits in DW bits.
      r_dout   <= w_grant[DW-1:0];
      r_valid  <= 1'b1;
      r_remain <= w_remain_after;
      r_ngrant <= r_ngrant + 4'd1;
    end else begin
      r_valid  <= 1'b0;
    end
  end

  assign dout   = r_dout;
  assign valid  = r_valid;
  assign remain = r_remain;
  assign ngrant = r_ngrant;
  assign busy   = w_busy;
  assign empty  = (r_remain == '0);

endmodule

// File: tb/tb_deaccumulation.sv
module tb_deaccumulation;

  localparam int DW = 4;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          load;
  logic [AW-1:0] total;
  logic          req;
  logic [DW-1:0] amt;
  logic [DW-1:0] dout;
  logic          valid;
  logic [AW-1:0] remain;
  logic          busy;
  logic          empty;
  logic [3:0]    ngrant;

  int n_vec;
  int n_miscmp;

  typedef struct {
    string         name;
    logic          load;
    logic [AW-1:0] total;
    logic          req;
    logic [DW-1:0] amt;
    logic [DW-1:0] dout;
    logic          valid;
    logic [AW-1:0] remain;
    logic [3:0]    ngrant;
    logic          busy;
    logic          empty;
  } vec_t;

  vec_t vecs[$];

  deaccumulation #(.DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .total  (total),
    .req    (req),
    .amt    (amt),
    .dout   (dout),
    .valid  (valid),
    .remain (remain),
    .busy   (busy),
    .empty  (empty),
    .ngrant (ngrant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input string name, input logic ld, input int tot, input logic rq,
                     input int am, input int e_dout, input logic e_valid, input int e_remain,
                     input int e_ngrant, input logic e_busy, input logic e_empty);
    vec_t v;
    v.name   = name;
    v.load   = ld;
    v.total  = AW'(tot);
    v.req    = rq;
    v.amt    = DW'(am);
    v.dout   = DW'(e_dout);
    v.valid  = e_valid;
    v.remain = AW'(e_remain);
    v.ngrant = 4'(e_ngrant);
    v.busy   = e_busy;
    v.empty  = e_empty;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int e_dout, input logic e_valid,
                       input int e_remain, input int e_ngrant, input logic e_busy,
                       input logic e_empty);
    logic [DW-1:0] xd;
    logic [AW-1:0] xr;
    logic [3:0]    xn;
    xd = DW'(e_dout);
    xr = AW'(e_remain);
    xn = 4'(e_ngrant);
    n_vec++;
    if (dout !== xd || valid !== e_valid || remain !== xr || ngrant !== xn ||
        busy !== e_busy || empty !== e_empty) begin
      n_miscmp++;
      $display("FAIL %s: got dout=%0d valid=%0b remain=%0d ngrant=%0d busy=%0b empty=%0b, want dout=%0d valid=%0b remain=%0d ngrant=%0d busy=%0b empty=%0b",
               name, dout, valid, remain, ngrant, busy, empty,
               xd, e_valid, xr, xn, e_busy, e_empty);
    end
  endtask

  task automatic drive(input logic ld, input int tot, input logic rq, input int am);
    load  = ld;
    total = AW'(tot);
    req   = rq;
    amt   = DW'(am);
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec    = 0;
    n_miscmp = 0;
    drive(1'b0, 0, 1'b0, 0);

    //   name            ld tot  rq amt  dout v rem ng busy empty
    add("load15",        1, 15,  0, 0,   0,  0, 15, 0, 1, 0);
    add("drain1",        0, 0,   1, 1,   1,  1, 14, 1, 1, 0);
    add("drain2",        0, 0,   1, 2,   2,  1, 12, 2, 1, 0);
    add("drain4",        0, 0,   1, 4,   4,  1, 8,  3, 1, 0);
    add("drain8",        0, 0,   1, 8,   8,  1, 0,  4, 0, 1);
    add("done_req",      0, 0,   1, 3,   8,  0, 0,  4, 0, 1);
    add("done_hold",     0, 0,   0, 0,   8,  0, 0,  4, 0, 1);
    add("load5",         1, 5,   0, 0,   8,  0, 5,  0, 1, 0);
    add("sat8",          0, 0,   1, 8,   5,  1, 0,  1, 0, 1);
    add("sat_after",     0, 0,   1, 8,   5,  0, 0,  1, 0, 1);
    add("load20",        1, 20,  0, 0,   5,  0, 20, 0, 1, 0);
    add("req3",          0, 0,   1, 3,   3,  1, 17, 1, 1, 0);
    add("load_beats_rq", 1, 40,  1, 9,   3,  0, 40, 0, 1, 0);
    add("drain_hold",    0, 0,   0, 0,   3,  0, 40, 0, 1, 0);
    add("amt0",          0, 0,   1, 0,   0,  1, 40, 1, 1, 0);
    add("amt15_a",       0, 0,   1, 15,  15, 1, 25, 2, 1, 0);
    add("amt15_b",       0, 0,   1, 15,  15, 1, 10, 3, 1, 0);
    add("amt15_sat",     0, 0,   1, 15,  10, 1, 0,  4, 0, 1);
    add("load0",         1, 0,   0, 0,   10, 0, 0,  0, 0, 1);
    add("load0_req",     0, 0,   1, 5,   10, 0, 0,  0, 0, 1);

    // Reset is asynchronous: outputs must clear before any clock edge.
    rst = 1'b0;
    #1;
    check("reset_async", 0, 1'b0, 0, 0, 1'b0, 1'b1);
    // A request in IDLE with no load must be ignored.
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 0, 1'b1, 5);
    step();
    check("idle_req", 0, 1'b0, 0, 0, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].load, int'(vecs[i].total), vecs[i].req, int'(vecs[i].amt));
      step();
      check(vecs[i].name, int'(vecs[i].dout), vecs[i].valid, int'(vecs[i].remain),
            int'(vecs[i].ngrant), vecs[i].busy, vecs[i].empty);
    end

    // ngrant wraps 15 -> 0 after sixteen grants.
    drive(1'b1, 200, 1'b0, 0);
    step();
    check("load200", 10, 1'b0, 200, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++) begin
      drive(1'b0, 0, 1'b1, 1);
      step();
      check($sformatf("wrap_%0d", k), 1, 1'b1, 200 - k, k % 16, 1'b1, 1'b0);
    end
    drive(1'b0, 0, 1'b0, 0);
    step();
    check("wrap_idle", 1, 1'b0, 184, 0, 1'b1, 1'b0);

    // Reset between edges mid-drain discards the balance.
    drive(1'b1, 100, 1'b0, 0);
    step();
    check("load100", 1, 1'b0, 100, 0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 10);
    step();
    check("req10", 10, 1'b1, 90, 1, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 0);
    #2;
    rst = 1'b0;
    #1;
    check("reset_mid", 0, 1'b0, 0, 0, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 0, 1'b1, 5);
    step();
    check("post_reset_req", 0, 1'b0, 0, 0, 1'b0, 1'b1);
    // First edge after release works normally.
    drive(1'b1, 7, 1'b0, 0);
    step();
    check("post_reset_load", 0, 1'b0, 7, 0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b1, 5);
    step();
    check("post_reset_grant", 5, 1'b1, 2, 1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
